pwm_peripheral: RTL and testbench
=================================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PRESCALE, default 3333, system clocks per PWM tick (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enable, channels 7..0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM-mode select, channels 7..0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM-mode select, channels 15..8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  duty cycle in 1/256 steps; 8'hFF means 100 %.
REQ-009 SHALL have port out  output  16  registered channel outputs; uo_out gets out[7:0], uio_out gets out[15:8].

Function
REQ-010 SHALL keep a 16-bit prescaler, 0..PRESCALE-1; tick is asserted in the cycle where prescaler == PRESCALE-1; prescaler wraps to 0 on the next edge.
REQ-011 SHALL keep an 8-bit pwm_cnt that increments on each tick and wraps from 255 to 0; PWM period = 256*PRESCALE clocks.
REQ-012 SHALL compute pwm_level = 1 when duty_eff == 8'hFF, otherwise (pwm_cnt < duty_eff).
REQ-013 SHALL set each bit i of the next out value: en_out[i]=0 -> 0; en_out[i]=1 and en_pwm[i]=0 -> 1; en_out[i]=1 and en_pwm[i]=1 -> pwm_level.
REQ-014 SHALL register out; a change on any enable/select input appears on out exactly 1 clock later.
REQ-015 SHALL give duty 0 a constant 0 and duty 8'hFF a constant 1 (no glitch pulse) on PWM channels.
REQ-016 SHALL make duty N (1..254) high for exactly N*PRESCALE clocks per period, starting at pwm_cnt == 0.
REQ-017 SHALL apply PRESCALE == 1 as a tick every clock: prescaler stays 0.
REQ-018 SHALL NOT reset or disturb the counters when enables or duty change; counting is free-running.

Reset
REQ-019 SHALL clear the prescaler, pwm_cnt, the duty shadow register and out to 0 when rst=1 at a clock edge.
REQ-020 SHALL restart counting from 0 on the first edge after rst deasserts when rst is asserted mid-period; no partial period is retained.
REQ-021 SHALL hold out at 16'h0000 during reset regardless of enable inputs.

Configuration
REQ-022 SHALL compile a shadowed duty cycle when macro PWM_DUTY_SHADOW_EN is defined: duty_eff is a register loaded from pwm_duty_cycle only on the edge where tick=1 and pwm_cnt==255, so a new duty takes effect at the next period start.
REQ-023 SHALL drive duty_eff = pwm_duty_cycle combinationally when PWM_DUTY_SHADOW_EN is undefined: a change takes effect at the next clock, mid-period.
REQ-024 SHALL keep all other behaviour identical with and without PWM_DUTY_SHADOW_EN.

Verification (PRESCALE=4 unless stated)
REQ-025 SHALL cover static outputs: rst, then en_reg_out_7_0=8'hA5, pwm=0 -> out[7:0]=8'hA5 one clock later, out[15:8]=0.
REQ-026 SHALL cover 50 % duty: channel 0 out+pwm enabled, duty=8'h80 -> high 512 clocks, low 512 clocks, period 1024 clocks.
REQ-027 SHALL cover duty extremes: duty=8'h00 -> out[0] constantly 0 over 2 periods; duty=8'hFF -> constantly 1 over 2 periods.
REQ-028 SHALL cover a mid-period duty change from 8'h40 to 8'hC0 at pwm_cnt=100: with macro, the current period stays high 256 clocks and the next is high 768; without macro, the current period's output rises again at the next clock.
REQ-029 SHALL cover reset mid-operation: rst=1 at pwm_cnt=77 -> out=0, counters 0; after release the first high pulse starts at the first clock after rst deasserts.
REQ-030 SHALL cover the upper bank: en_reg_out_15_8=8'h80, en_reg_pwm_15_8=8'h80, duty=8'h20, PRESCALE=1 -> out[15] high 32 of every 256 clocks.

Source files
------------

// File: rtl/pwm_peripheral.sv
// 16-channel output block: each channel is off, static high, or driven by a shared
// prescaled 8-bit PWM counter. Define PWM_DUTY_SHADOW_EN to latch duty only at period start.
module pwm_peripheral #(
  parameter int PRESCALE = 3333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescaler_q;
  logic [15:0] prescaler_d;
  logic [7:0]  pwm_cnt_q;
  logic [7:0]  pwm_cnt_d;
  logic [15:0] out_q;
  logic [15:0] out_d;
  logic        tick_s;
  logic        pwm_level_s;
  logic [7:0]  duty_eff_s;
  logic [15:0] en_out_s;
  logic [15:0] en_pwm_s;

  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out      = out_q;

  // Free-running prescaler and PWM counter; enables and duty never touch them.
  always_comb begin
    tick_s = (prescaler_q == PRESCALE_LAST);
    if (tick_s) begin
      prescaler_d = 16'd0;
      pwm_cnt_d   = pwm_cnt_q + 8'd1;
    end else begin
      prescaler_d = prescaler_q + 16'd1;
      pwm_cnt_d   = pwm_cnt_q;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_shadow_q;
  logic [7:0] duty_shadow_d;

  // Duty sampled on the last tick of a period so the new value starts with pwm_cnt == 0.
  always_comb begin
    if (tick_s && (pwm_cnt_q == 8'hFF)) begin
      duty_shadow_d = pwm_duty_cycle;
    end else begin
      duty_shadow_d = duty_shadow_q;
    end
  end

  // Shadow duty register.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_q <= 8'd0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
    end
  end

  assign duty_eff_s = duty_shadow_q;
`else
  assign duty_eff_s = pwm_duty_cycle;
`endif

  // Full scale is forced high so 8'hFF never shows a one-count low glitch.
  always_comb begin
    if (duty_eff_s == 8'hFF) begin
      pwm_level_s = 1'b1;
    end else begin
      pwm_level_s = (pwm_cnt_q < duty_eff_s);
    end
  end

  // Per-channel output select.
  always_comb begin
    out_d = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      case ({en_out_s[i], en_pwm_s[i]})
        2'b10:   out_d[i] = 1'b1;
        2'b11:   out_d[i] = pwm_level_s;
        default: out_d[i] = 1'b0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      out_q       <= 16'h0000;
    end else begin
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: stimulus queues expected windows, a monitor checks them.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_out_lo;
  logic [7:0]  en_out_hi;
  logic [7:0]  en_pwm_lo;
  logic [7:0]  en_pwm_hi;
  logic [7:0]  duty;
  logic [15:0] out4;
  logic [15:0] out1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int t0;
  int t1;

  typedef struct {
    string       name;
    int          start;
    int          len;
    bit          count_mode;
    bit          use_dut1;
    logic [15:0] mask;
    int          exp;
  } chk_t;

  chk_t sb[$];

  chk_t        cur;
  bit          active = 1'b0;
  bit          began;
  bit          ok;
  int          acc;
  int          bad_cyc;
  logic [15:0] bad_val;
  logic [15:0] v;

  pwm_peripheral #(.PRESCALE(4)) u_dut4 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out             (out4)
  );

  pwm_peripheral #(.PRESCALE(1)) u_dut1 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out             (out1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // count_mode=0: (out & mask) must equal exp on every cycle of the window.
  // count_mode=1: number of cycles with (out & mask) != 0 must equal exp.
  function automatic void expect_win(input string name, input int start, input int len,
                                     input bit count_mode, input bit use_dut1,
                                     input logic [15:0] mask, input int exp);
    chk_t c;
    c.name = name;
    c.start = start;
    c.len = len;
    c.count_mode = count_mode;
    c.use_dut1 = use_dut1;
    c.mask = mask;
    c.exp = exp;
    sb.push_back(c);
  endfunction

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!active && sb.size() > 0) begin
        cur = sb.pop_front();
        active = 1'b1;
        began = 1'b0;
        ok = 1'b1;
        acc = 0;
      end
      if (active) begin
        if (!began && cyc > cur.start) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: window began at cyc %0d, required start cyc %0d", cur.name, cyc, cur.start);
          active = 1'b0;
        end else if (cyc >= cur.start) begin
          began = 1'b1;
          v = cur.use_dut1 ? out1 : out4;
          if (cur.count_mode) begin
            if ((v & cur.mask) !== 16'h0000) acc++;
          end else if (ok && ((v & cur.mask) !== 16'(cur.exp))) begin
            ok = 1'b0;
            bad_val = v & cur.mask;
            bad_cyc = cyc;
          end
          if (cyc == cur.start + cur.len - 1) begin
            n_checks++;
            if (cur.count_mode && (acc != cur.exp)) begin
              n_errors++;
              $display("FAIL %s: got %0d high cycles, expected %0d", cur.name, acc, cur.exp);
            end else if (!cur.count_mode && !ok) begin
              n_errors++;
              $display("FAIL %s: got %h at cyc %0d, expected %h", cur.name, bad_val, bad_cyc, 16'(cur.exp));
            end
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    en_out_lo = 8'hFF;
    en_out_hi = 8'hFF;
    en_pwm_lo = 8'h00;
    en_pwm_hi = 8'h00;
    duty = 8'h00;

    // Reset holds out at zero even with every channel enabled.
    expect_win("reset_dut4", 2, 1, 1'b0, 1'b0, 16'hFFFF, 0);
    expect_win("reset_dut1", 3, 1, 1'b0, 1'b1, 16'hFFFF, 0);
    goto_cyc(3);
    t0 = cyc;
    rst = 1'b0;
    en_out_lo = 8'hA5;
    en_out_hi = 8'h00;

    // Static outputs, one clock latency.
    expect_win("static_lo", t0 + 1, 3, 1'b0, 1'b0, 16'hFFFF, 32'h00A5);
    goto_cyc(t0 + 4);
    en_out_lo = 8'h00;
    en_out_hi = 8'h3C;
    expect_win("static_hi", t0 + 5, 3, 1'b0, 1'b0, 16'hFFFF, 32'h3C00);

    // 50 % duty on channel 0, PRESCALE=4: 512 high then 512 low per 1024-clock period.
    goto_cyc(t0 + 10);
    en_out_hi = 8'h00;
    en_out_lo = 8'h01;
    en_pwm_lo = 8'h01;
    duty = 8'h80;
    expect_win("duty50_high", t0 + 1025, 512, 1'b0, 1'b0, 16'h0001, 1);
    expect_win("duty50_low", t0 + 1537, 512, 1'b0, 1'b0, 16'h0001, 0);
    expect_win("duty50_count", t0 + 2049, 1024, 1'b1, 1'b0, 16'h0001, 512);

    // Duty extremes, changed just before a period boundary.
    goto_cyc(t0 + 3071);
    duty = 8'h00;
    expect_win("duty00_const", t0 + 3073, 2047, 1'b0, 1'b0, 16'h0001, 0);
    goto_cyc(t0 + 5119);
    duty = 8'hFF;
    expect_win("dutyFF_const", t0 + 5121, 2047, 1'b0, 1'b0, 16'h0001, 1);

    // Mid-period change 8'h40 -> 8'hC0 at pwm_cnt == 100.
    goto_cyc(t0 + 7167);
    duty = 8'h40;
    expect_win("mid_first_high", t0 + 7169, 256, 1'b0, 1'b0, 16'h0001, 1);
`ifdef PWM_DUTY_SHADOW_EN
    expect_win("mid_rest_low", t0 + 7425, 768, 1'b0, 1'b0, 16'h0001, 0);
`else
    expect_win("mid_gap_low", t0 + 7425, 144, 1'b0, 1'b0, 16'h0001, 0);
    expect_win("mid_rise_again", t0 + 7569, 368, 1'b0, 1'b0, 16'h0001, 1);
    expect_win("mid_tail_low", t0 + 7937, 256, 1'b0, 1'b0, 16'h0001, 0);
`endif
    expect_win("mid_next_count", t0 + 8193, 1024, 1'b1, 1'b0, 16'h0001, 768);
    goto_cyc(t0 + 7568);
    duty = 8'hC0;

    // Reset at pwm_cnt == 77 with all channels forced static-enabled.
    goto_cyc(t0 + 9524);
    rst = 1'b1;
    en_out_lo = 8'hFF;
    en_out_hi = 8'hFF;
    en_pwm_lo = 8'h00;
    expect_win("rst_mid_zero", t0 + 9525, 2, 1'b0, 1'b0, 16'hFFFF, 0);
    goto_cyc(t0 + 9526);
    t1 = cyc;
    rst = 1'b0;
    en_out_lo = 8'h01;
    en_out_hi = 8'h00;
    en_pwm_lo = 8'h01;
`ifdef PWM_DUTY_SHADOW_EN
    expect_win("rst_shadow_low", t1 + 1, 1024, 1'b0, 1'b0, 16'hFFFF, 0);
    expect_win("rst_shadow_high", t1 + 1025, 768, 1'b0, 1'b0, 16'hFFFF, 1);
`else
    expect_win("rst_first_high", t1 + 1, 768, 1'b0, 1'b0, 16'hFFFF, 1);
    expect_win("rst_first_low", t1 + 769, 256, 1'b0, 1'b0, 16'hFFFF, 0);
`endif

    // Upper bank on the PRESCALE=1 instance: out[15] high 32 of every 256 clocks.
    goto_cyc(t1 + 2047);
    en_out_lo = 8'h00;
    en_pwm_lo = 8'h00;
    en_out_hi = 8'h80;
    en_pwm_hi = 8'h80;
    duty = 8'h20;
    expect_win("hi_bank_high", t1 + 2049, 32, 1'b0, 1'b1, 16'hFFFF, 32'h8000);
    expect_win("hi_bank_low", t1 + 2081, 224, 1'b0, 1'b1, 16'hFFFF, 0);
    expect_win("hi_bank_count1", t1 + 2305, 256, 1'b1, 1'b1, 16'h8000, 32);
    expect_win("hi_bank_count2", t1 + 2561, 256, 1'b1, 1'b1, 16'h8000, 32);

    goto_cyc(t1 + 2817);
    for (int k = 0; k < 50 && (active || sb.size() > 0); k++) @(negedge clk);
    if (active || sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d windows pending, expected 0", sb.size() + 32'(active));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
